// File: rtl/grid_cursor.sv
// -----------------------------------------------------------------------------
// grid_cursor
//
// Moves a sprite one cell per button press across a COLS x ROWS grid of
// screen cells. It reports the sprite's top-left pixel position and the
// linear cell index used to address sprite memory.
//
// Button inputs are levels. Only a rising edge counts as a move event, so a
// held button moves the sprite exactly once. At the grid edges the cursor
// either wraps around (WRAP=1) or stays where it is (WRAP=0). A home event
// returns the cursor to cell (0,0) and wins over any move in the same cycle.
//
// Ports:
//   clk            system clock (pixel clock domain)
//   rst            synchronous, active-high reset
//   x_inc, x_dec   move right / left (level)
//   y_inc, y_dec   move down / up (level)
//   home           return to cell (0,0) (level)
//   posx, posy     pixel position of the current cell (registered)
//   player_address linear cell index row*COLS+col (registered)
//   moved          one-cycle pulse after any update that changed the cell
// -----------------------------------------------------------------------------
module grid_cursor #(
    parameter int COLS = 3,
    parameter int ROWS = 3,
    parameter int X0   = 200,
    parameter int Y0   = 100,
    parameter int DX   = 300,
    parameter int DY   = 150,
    parameter int W    = 10,
    parameter int WRAP = 1,
    parameter int IW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_inc,
    input  logic          x_dec,
    input  logic          y_inc,
    input  logic          y_dec,
    input  logic          home,
    output logic [W-1:0]  posx,
    output logic [W-1:0]  posy,
    output logic [IW-1:0] player_address,
    output logic          moved
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Reject parameter sets whose positions or index would not fit.
    if (COLS < 1 || ROWS < 1) begin : g_bad_dims
        $fatal(1, "grid_cursor: COLS and ROWS must be at least 1");
    end
    if ((longint'(X0) + longint'(COLS - 1) * longint'(DX)) >= (longint'(1) << W)) begin : g_bad_x
        $fatal(1, "grid_cursor: X0+(COLS-1)*DX does not fit in W bits");
    end
    if ((longint'(Y0) + longint'(ROWS - 1) * longint'(DY)) >= (longint'(1) << W)) begin : g_bad_y
        $fatal(1, "grid_cursor: Y0+(ROWS-1)*DY does not fit in W bits");
    end
    if ((longint'(COLS) * longint'(ROWS)) > (longint'(1) << IW)) begin : g_bad_idx
        $fatal(1, "grid_cursor: COLS*ROWS does not fit in IW bits");
    end

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic          x_inc_prev_r;
    logic          x_dec_prev_r;
    logic          y_inc_prev_r;
    logic          y_dec_prev_r;
    logic          home_prev_r;
    logic [W-1:0]  posx_r;
    logic [W-1:0]  posy_r;
    logic [IW-1:0] addr_r;
    logic          moved_r;

    logic          x_inc_ev_s;
    logic          x_dec_ev_s;
    logic          y_inc_ev_s;
    logic          y_dec_ev_s;
    logic          home_ev_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic          changed_s;
    logic [W-1:0]  posx_nxt_s;
    logic [W-1:0]  posy_nxt_s;
    logic [IW-1:0] addr_nxt_s;

    // Rising-edge detection against the previous input levels.
    always_comb begin
        x_inc_ev_s = x_inc & ~x_inc_prev_r;
        x_dec_ev_s = x_dec & ~x_dec_prev_r;
        y_inc_ev_s = y_inc & ~y_inc_prev_r;
        y_dec_ev_s = y_dec & ~y_dec_prev_r;
        home_ev_s  = home  & ~home_prev_r;
    end

    // Next column. Opposing events cancel. At an edge the step wraps or is dropped.
    always_comb begin
        col_nxt_s = col_r;
        if (COLS > 1) begin
            if (x_inc_ev_s && !x_dec_ev_s) begin
                if (col_r == COL_LAST) begin
                    col_nxt_s = (WRAP != 0) ? CW'(0) : col_r;
                end else begin
                    col_nxt_s = col_r + CW'(1);
                end
            end else if (x_dec_ev_s && !x_inc_ev_s) begin
                if (col_r == CW'(0)) begin
                    col_nxt_s = (WRAP != 0) ? COL_LAST : col_r;
                end else begin
                    col_nxt_s = col_r - CW'(1);
                end
            end else begin
                col_nxt_s = col_r;
            end
        end else begin
            col_nxt_s = CW'(0);
        end
        if (home_ev_s) begin
            col_nxt_s = CW'(0);
        end else begin
            col_nxt_s = col_nxt_s;
        end
    end

    // Next row. The logic mirrors the column axis.
    always_comb begin
        row_nxt_s = row_r;
        if (ROWS > 1) begin
            if (y_inc_ev_s && !y_dec_ev_s) begin
                if (row_r == ROW_LAST) begin
                    row_nxt_s = (WRAP != 0) ? RW'(0) : row_r;
                end else begin
                    row_nxt_s = row_r + RW'(1);
                end
            end else if (y_dec_ev_s && !y_inc_ev_s) begin
                if (row_r == RW'(0)) begin
                    row_nxt_s = (WRAP != 0) ? ROW_LAST : row_r;
                end else begin
                    row_nxt_s = row_r - RW'(1);
                end
            end else begin
                row_nxt_s = row_r;
            end
        end else begin
            row_nxt_s = RW'(0);
        end
        if (home_ev_s) begin
            row_nxt_s = RW'(0);
        end else begin
            row_nxt_s = row_nxt_s;
        end
    end

    // Derived outputs come from the next cell, so they line up with the cell registers.
    // The elaboration checks guarantee that none of these W/IW-bit sums overflow.
    always_comb begin
        changed_s  = (col_nxt_s != col_r) || (row_nxt_s != row_r);
        posx_nxt_s = W'(X0) + W'(col_nxt_s) * W'(DX);
        posy_nxt_s = W'(Y0) + W'(row_nxt_s) * W'(DY);
        addr_nxt_s = IW'(row_nxt_s) * IW'(COLS) + IW'(col_nxt_s);
    end

    // State and output registers. Reset overrides every event in its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r        <= CW'(0);
            row_r        <= RW'(0);
            // Start high so that an input already held at reset release is not a move.
            x_inc_prev_r <= 1'b1;
            x_dec_prev_r <= 1'b1;
            y_inc_prev_r <= 1'b1;
            y_dec_prev_r <= 1'b1;
            home_prev_r  <= 1'b1;
            posx_r       <= W'(X0);
            posy_r       <= W'(Y0);
            addr_r       <= IW'(0);
            moved_r      <= 1'b0;
        end else begin
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            x_inc_prev_r <= x_inc;
            x_dec_prev_r <= x_dec;
            y_inc_prev_r <= y_inc;
            y_dec_prev_r <= y_dec;
            home_prev_r  <= home;
            posx_r       <= posx_nxt_s;
            posy_r       <= posy_nxt_s;
            addr_r       <= addr_nxt_s;
            moved_r      <= changed_s;
        end
    end

    assign posx           = posx_r;
    assign posy           = posy_r;
    assign player_address = addr_r;
    assign moved          = moved_r;

endmodule

// File: tb/tb_grid_cursor.sv
// -----------------------------------------------------------------------------
// tb_grid_cursor
//
// Directed test of grid_cursor with three instances:
//   u_a : default parameters (3x3, wrap)
//   u_b : 3x3 with saturating edges
//   u_c : 4x2 grid, X0=0, DX=160, DY=240, IW=3
// Button vector bit map: 0 x_inc, 1 x_dec, 2 y_inc, 3 y_dec, 4 home.
// Inputs change 1 time unit after a rising edge. Outputs are checked
// 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_grid_cursor;

    logic       clk;
    logic       rst;
    logic [4:0] ba;
    logic [4:0] bb;
    logic [4:0] bc;

    logic [9:0] a_x;
    logic [9:0] a_y;
    logic [3:0] a_adr;
    logic       a_mv;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic [3:0] b_adr;
    logic       b_mv;
    logic [9:0] c_x;
    logic [9:0] c_y;
    logic [2:0] c_adr;
    logic       c_mv;

    int errors;
    int checks;

    grid_cursor u_a (
        .clk(clk), .rst(rst),
        .x_inc(ba[0]), .x_dec(ba[1]), .y_inc(ba[2]), .y_dec(ba[3]), .home(ba[4]),
        .posx(a_x), .posy(a_y), .player_address(a_adr), .moved(a_mv)
    );

    grid_cursor #(.WRAP(0)) u_b (
        .clk(clk), .rst(rst),
        .x_inc(bb[0]), .x_dec(bb[1]), .y_inc(bb[2]), .y_dec(bb[3]), .home(bb[4]),
        .posx(b_x), .posy(b_y), .player_address(b_adr), .moved(b_mv)
    );

    grid_cursor #(.COLS(4), .ROWS(2), .X0(0), .DX(160), .DY(240), .IW(3)) u_c (
        .clk(clk), .rst(rst),
        .x_inc(bc[0]), .x_dec(bc[1]), .y_inc(bc[2]), .y_dec(bc[3]), .home(bc[4]),
        .posx(c_x), .posy(c_y), .player_address(c_adr), .moved(c_mv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        ba  = 5'b00001;          // x_inc held across reset release
        bb  = 5'b00000;
        bc  = 5'b00000;
        tick();
        tick();
        chk("rst_posx", 32'(a_x), 32'd200);
        chk("rst_posy", 32'(a_y), 32'd100);
        chk("rst_addr", 32'(a_adr), 32'd0);
        chk("rst_moved", 32'(a_mv), 32'd0);
        chk("rst_c_posx", 32'(c_x), 32'd0);

        rst = 1'b0;
        tick();
        chk("held_posx", 32'(a_x), 32'd200);
        chk("held_moved", 32'(a_mv), 32'd0);
        tick();
        chk("held2_addr", 32'(a_adr), 32'd0);
        ba = 5'b00000;
        tick();
        chk("release_moved", 32'(a_mv), 32'd0);

        // Three x_inc presses with wrap: 500, 800, then 200.
        ba = 5'b00001; tick();
        chk("xi1_posx", 32'(a_x), 32'd500);
        chk("xi1_addr", 32'(a_adr), 32'd1);
        chk("xi1_moved", 32'(a_mv), 32'd1);
        ba = 5'b00000; tick();
        chk("xi1_moved_off", 32'(a_mv), 32'd0);
        ba = 5'b00001; tick();
        chk("xi2_posx", 32'(a_x), 32'd800);
        chk("xi2_addr", 32'(a_adr), 32'd2);
        chk("xi2_moved", 32'(a_mv), 32'd1);
        ba = 5'b00000; tick();
        chk("xi2_moved_off", 32'(a_mv), 32'd0);
        ba = 5'b00001; tick();
        chk("xi3_posx", 32'(a_x), 32'd200);
        chk("xi3_addr", 32'(a_adr), 32'd0);
        chk("xi3_moved", 32'(a_mv), 32'd1);
        ba = 5'b00000; tick();

        // Diagonal from (0,0) to (1,1).
        ba = 5'b00101; tick();
        chk("diag_posx", 32'(a_x), 32'd500);
        chk("diag_posy", 32'(a_y), 32'd250);
        chk("diag_addr", 32'(a_adr), 32'd4);
        chk("diag_moved", 32'(a_mv), 32'd1);
        ba = 5'b00000; tick();
        chk("diag_moved_off", 32'(a_mv), 32'd0);

        // x_inc and x_dec in the same cycle cancel.
        ba = 5'b00011; tick();
        chk("cancel_posx", 32'(a_x), 32'd500);
        chk("cancel_moved", 32'(a_mv), 32'd0);
        ba = 5'b00000; tick();

        // Go to (2,2), then home together with x_dec.
        ba = 5'b00001; tick();
        ba = 5'b00000; tick();
        ba = 5'b00100; tick();
        chk("at22_addr", 32'(a_adr), 32'd8);
        ba = 5'b00000; tick();
        ba = 5'b10010; tick();
        chk("home_addr", 32'(a_adr), 32'd0);
        chk("home_posx", 32'(a_x), 32'd200);
        chk("home_posy", 32'(a_y), 32'd100);
        chk("home_moved", 32'(a_mv), 32'd1);
        ba = 5'b00000; tick();
        ba = 5'b10000; tick();
        chk("home00_moved", 32'(a_mv), 32'd0);
        chk("home00_addr", 32'(a_adr), 32'd0);
        ba = 5'b00000; tick();

        // Wrap downward from column 0 and row 0.
        ba = 5'b00010; tick();
        chk("xdec_wrap_posx", 32'(a_x), 32'd800);
        chk("xdec_wrap_addr", 32'(a_adr), 32'd2);
        chk("xdec_wrap_moved", 32'(a_mv), 32'd1);
        ba = 5'b00000; tick();
        ba = 5'b01000; tick();
        chk("ydec_wrap_posy", 32'(a_y), 32'd400);
        chk("ydec_wrap_addr", 32'(a_adr), 32'd8);
        ba = 5'b00000; tick();

        // Saturating instance: y_dec at row 0, then y_inc three times.
        bb = 5'b01000; tick();
        chk("sat_ydec_posy", 32'(b_y), 32'd100);
        chk("sat_ydec_moved", 32'(b_mv), 32'd0);
        bb = 5'b00000; tick();
        bb = 5'b00100; tick();
        chk("sat_yi1_posy", 32'(b_y), 32'd250);
        chk("sat_yi1_addr", 32'(b_adr), 32'd3);
        chk("sat_yi1_moved", 32'(b_mv), 32'd1);
        bb = 5'b00000; tick();
        bb = 5'b00100; tick();
        chk("sat_yi2_posy", 32'(b_y), 32'd400);
        chk("sat_yi2_addr", 32'(b_adr), 32'd6);
        bb = 5'b00000; tick();
        bb = 5'b00100; tick();
        chk("sat_yi3_posy", 32'(b_y), 32'd400);
        chk("sat_yi3_addr", 32'(b_adr), 32'd6);
        chk("sat_yi3_moved", 32'(b_mv), 32'd0);
        bb = 5'b00000; tick();
        bb = 5'b00010; tick();
        chk("sat_xdec_posx", 32'(b_x), 32'd200);
        chk("sat_xdec_moved", 32'(b_mv), 32'd0);
        bb = 5'b00000; tick();

        // 4x2 grid walk: 0,1,2,3, then 7,6,5,4.
        bc = 5'b00001; tick();
        chk("c_addr1", 32'(c_adr), 32'd1);
        chk("c_posx1", 32'(c_x), 32'd160);
        bc = 5'b00000; tick();
        bc = 5'b00001; tick();
        chk("c_addr2", 32'(c_adr), 32'd2);
        chk("c_posx2", 32'(c_x), 32'd320);
        bc = 5'b00000; tick();
        bc = 5'b00001; tick();
        chk("c_addr3", 32'(c_adr), 32'd3);
        chk("c_posx3", 32'(c_x), 32'd480);
        bc = 5'b00000; tick();
        bc = 5'b00100; tick();
        chk("c_addr7", 32'(c_adr), 32'd7);
        chk("c_posy7", 32'(c_y), 32'd340);
        bc = 5'b00000; tick();
        bc = 5'b00010; tick();
        chk("c_addr6", 32'(c_adr), 32'd6);
        chk("c_posx6", 32'(c_x), 32'd320);
        bc = 5'b00000; tick();
        bc = 5'b00010; tick();
        chk("c_addr5", 32'(c_adr), 32'd5);
        bc = 5'b00000; tick();
        bc = 5'b00010; tick();
        chk("c_addr4", 32'(c_adr), 32'd4);
        chk("c_posx4", 32'(c_x), 32'd0);
        chk("c_moved4", 32'(c_mv), 32'd1);
        bc = 5'b00000; tick();
        bc = 5'b00001; tick();
        chk("c_addr5b", 32'(c_adr), 32'd5);
        bc = 5'b00000; tick();

        // Reset mid-walk, with a rising x_inc in the same cycle.
        bc  = 5'b00001;
        rst = 1'b1; tick();
        chk("c_rst_addr", 32'(c_adr), 32'd0);
        chk("c_rst_posx", 32'(c_x), 32'd0);
        chk("c_rst_posy", 32'(c_y), 32'd100);
        chk("c_rst_moved", 32'(c_mv), 32'd0);
        rst = 1'b0; tick();
        chk("c_post_rst_addr", 32'(c_adr), 32'd0);
        chk("c_post_rst_moved", 32'(c_mv), 32'd0);
        bc = 5'b00000; tick();
        bc = 5'b00001; tick();
        chk("c_after_addr", 32'(c_adr), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
